sdr_wr_burst_feeder: RTL and testbench

Write-burst data sequencer that sits directly upstream of the SDRAM data path stage and drives its `DATAIN`/`DM` inputs. On a write-start pulse from the command path it pops exactly one word per clock from a show-ahead write FIFO for the requested burst length, registering data and byte masks so they line up with the WRITE command. FIFO underrun produces masked beats rather than stalls, because an SDRAM burst cannot pause. Refresh preemption is handled as an abort.

---
 rtl/sdr_wr_burst_feeder_pkg.sv | 20 ++
 rtl/sdr_wr_burst_feeder_if.sv | 36 +++
 rtl/sdr_wr_burst_feeder.sv | 79 +++++++
 tb/tb_sdr_wr_burst_feeder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_wr_burst_feeder_pkg.sv
// Shared SDRAM parameters for the write data path: data/mask widths, the
// burst-length field used by both the command path and the write feeder,
// and the feeder state encoding.
package sdr_wr_burst_feeder_pkg;

  localparam int DSIZE = 32;
  localparam int DM_W  = DSIZE / 8;
  localparam int BL_W  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;

  // Number of beats a WR_LEN value (beats minus one) produces.
  function automatic logic [BL_W:0] burst_beats(input logic [BL_W-1:0] len);
    return {1'b0, len} + 1'b1;
  endfunction

endpackage

// File: rtl/sdr_wr_burst_feeder_if.sv
// Signal bundle between the command path / write FIFO and the write feeder.
//
// Handshakes:
//   - WR_START is a one-cycle request; it is only accepted while WR_BUSY is
//     low and WR_ABORT is low. WR_LEN is sampled in the same cycle.
//   - FIFO_RDREQ high at a rising clock edge consumes the word currently on
//     FIFO_Q (show-ahead FIFO). It is never asserted while FIFO_EMPTY is high.
//   - WR_DONE is a one-cycle completion pulse; an aborted burst has none.
interface sdr_wr_burst_feeder_if;
  import sdr_wr_burst_feeder_pkg::*;

  logic            WR_START;
  logic [BL_W-1:0] WR_LEN;
  logic            WR_ABORT;
  logic [DSIZE-1:0] FIFO_Q;
  logic            FIFO_EMPTY;
  logic            FIFO_RDREQ;
  logic [DSIZE-1:0] DATAIN;
  logic [DM_W-1:0] DM;
  logic            WR_BUSY;
  logic            WR_DONE;
  logic            UNDERRUN;

  // Command path / FIFO side.
  modport master (
    output WR_START, WR_LEN, WR_ABORT, FIFO_Q, FIFO_EMPTY,
    input  FIFO_RDREQ, DATAIN, DM, WR_BUSY, WR_DONE, UNDERRUN
  );

  // Write feeder side.
  modport slave (
    input  WR_START, WR_LEN, WR_ABORT, FIFO_Q, FIFO_EMPTY,
    output FIFO_RDREQ, DATAIN, DM, WR_BUSY, WR_DONE, UNDERRUN
  );

endinterface

// File: rtl/sdr_wr_burst_feeder.sv
// Write-burst data sequencer. Pops one word per clock from a show-ahead FIFO
// for the requested burst length and registers data/masks toward the SDRAM
// data path. An empty FIFO yields a masked beat (a burst cannot stall);
// WR_ABORT ends the burst immediately without a completion pulse.
module sdr_wr_burst_feeder
  import sdr_wr_burst_feeder_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET_N,
  sdr_wr_burst_feeder_if.slave   bus,
  output wr_state_e              STATE_DBG
);

  wr_state_e        state;
  logic [BL_W-1:0]  cnt;
  logic [DSIZE-1:0] datain_q;
  logic [DM_W-1:0]  dm_q;
  logic             wr_done_q;
  logic             underrun_q;

  // Pop whenever a beat is issued with data available; abort suppresses it.
  always_comb begin
    bus.FIFO_RDREQ = (state == ST_BURST) && !bus.FIFO_EMPTY && !bus.WR_ABORT;
  end

  // Burst FSM with counter and registered data/mask outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      datain_q   <= '0;
      dm_q       <= '1;
      wr_done_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      // Default beat is fully masked; only a real pop unmasks it.
      datain_q  <= '0;
      dm_q      <= '1;
      wr_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.WR_START && !bus.WR_ABORT) begin
            cnt        <= bus.WR_LEN;
            underrun_q <= 1'b0;
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (bus.WR_ABORT) begin
            state <= ST_IDLE;
          end else begin
            if (!bus.FIFO_EMPTY) begin
              datain_q <= bus.FIFO_Q;
              dm_q     <= '0;
            end else begin
              underrun_q <= 1'b1;
            end
            // cnt holds remaining beats minus one, so 0 marks the last beat.
            if (cnt == '0) begin
              state     <= ST_IDLE;
              wr_done_q <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.DATAIN   = datain_q;
  assign bus.DM       = dm_q;
  assign bus.WR_DONE  = wr_done_q;
  assign bus.UNDERRUN = underrun_q;
  assign bus.WR_BUSY  = (state == ST_BURST);
  assign STATE_DBG    = state;

endmodule

// File: tb/tb_sdr_wr_burst_feeder.sv
// Directed bench for sdr_wr_burst_feeder with a queue-based show-ahead FIFO.
module tb_sdr_wr_burst_feeder;
  import sdr_wr_burst_feeder_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  sdr_wr_burst_feeder_if bus ();
  wr_state_e STATE_DBG;

  sdr_wr_burst_feeder dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .STATE_DBG (STATE_DBG)
  );

  // ---------------- FIFO model ----------------
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  logic             force_empty = 1'b0;
  int               pop_cnt = 0;

  always @(posedge CLK) begin
    if (bus.FIFO_RDREQ) begin
      pop_cnt++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
  end

  always @(negedge CLK) begin
    bus.FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
    bus.FIFO_Q     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  // One cycle step: inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_burst(input logic [BL_W-1:0] len);
    bus.WR_LEN   = len;
    bus.WR_START = 1'b1;
    tick();
    bus.WR_START = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N      = 1'b0;
    bus.WR_START = 1'b0;
    bus.WR_LEN   = '0;
    bus.WR_ABORT = 1'b0;
    fifo_q.push_back(32'h1234_5678);
    tick(); tick();
    if (bus.DATAIN !== 32'h0) begin $display("FAIL reset_datain: got %h expected %h", bus.DATAIN, 32'h0); end else n_pass++;
    n_total++;
    if (bus.DM !== 4'hF) begin $display("FAIL reset_dm: got %h expected %h", bus.DM, 4'hF); end else n_pass++;
    n_total++;
    if ({bus.WR_BUSY, bus.WR_DONE, bus.UNDERRUN, bus.FIFO_RDREQ} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b expected 0000", {bus.WR_BUSY, bus.WR_DONE, bus.UNDERRUN, bus.FIFO_RDREQ});
    end else n_pass++;
    n_total++;
    if (STATE_DBG !== ST_IDLE) begin $display("FAIL reset_state: got %0d expected %0d", STATE_DBG, ST_IDLE); end else n_pass++;
    n_total++;
    RESET_N = 1'b1;
    tick(); tick();
    if (pop_cnt !== 0) begin $display("FAIL reset_idle_pops: got %0d expected 0", pop_cnt); end else n_pass++;
    n_total++;
    fifo_q.delete();
    tick();
  endtask

  task automatic test_basic_burst();
    int p0;
    logic [DSIZE-1:0] exp;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(32'hA0 + i);
      exp_q.push_back(32'hA0 + i);
    end
    start_burst(8'd3);                       // now at T+1
    if (bus.WR_BUSY !== 1'b1 || bus.FIFO_RDREQ !== 1'b1) begin
      $display("FAIL basic_busy_rdreq: got %b%b expected 11", bus.WR_BUSY, bus.FIFO_RDREQ);
    end else n_pass++;
    n_total++;
    for (int k = 0; k < 4; k++) begin
      tick();                                // T+2+k
      exp = exp_q.pop_front();
      if (bus.DATAIN !== exp || bus.DM !== 4'h0) begin
        $display("FAIL basic_beat%0d: got %h/%h expected %h/0", k, bus.DATAIN, bus.DM, exp);
      end else n_pass++;
      n_total++;
      if (bus.WR_DONE !== (k == 3)) begin
        $display("FAIL basic_done_beat%0d: got %b expected %b", k, bus.WR_DONE, (k == 3));
      end else n_pass++;
      n_total++;
    end
    tick();                                  // T+6
    if (bus.DM !== 4'hF || bus.DATAIN !== 32'h0 || bus.WR_BUSY !== 1'b0) begin
      $display("FAIL basic_after: got dm=%h data=%h busy=%b expected dm=f data=0 busy=0", bus.DM, bus.DATAIN, bus.WR_BUSY);
    end else n_pass++;
    n_total++;
    if (pop_cnt - p0 !== 4) begin $display("FAIL basic_pops: got %0d expected 4", pop_cnt - p0); end else n_pass++;
    n_total++;
  endtask

  task automatic test_underrun();
    int p0;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hB0 + i);
    start_burst(8'd3);                       // T+1
    tick();                                  // T+2
    if (bus.DATAIN !== 32'hB0 || bus.UNDERRUN !== 1'b0) begin
      $display("FAIL under_beat0: got %h und=%b expected b0 und=0", bus.DATAIN, bus.UNDERRUN);
    end else n_pass++;
    n_total++;
    tick();                                  // T+3: FIFO looks empty for beat 2
    force_empty = 1'b1;
    tick();                                  // T+4
    force_empty = 1'b0;
    if (bus.DATAIN !== 32'h0 || bus.DM !== 4'hF || bus.UNDERRUN !== 1'b1) begin
      $display("FAIL under_beat2: got %h/%h und=%b expected 0/f und=1", bus.DATAIN, bus.DM, bus.UNDERRUN);
    end else n_pass++;
    n_total++;
    tick();                                  // T+5
    if (bus.DATAIN !== 32'hB2 || bus.DM !== 4'h0 || bus.WR_DONE !== 1'b1 || bus.UNDERRUN !== 1'b1) begin
      $display("FAIL under_beat3: got %h/%h done=%b und=%b expected b2/0 done=1 und=1", bus.DATAIN, bus.DM, bus.WR_DONE, bus.UNDERRUN);
    end else n_pass++;
    n_total++;
    tick(); tick();                          // T+7
    if (bus.UNDERRUN !== 1'b1) begin $display("FAIL under_sticky: got %b expected 1", bus.UNDERRUN); end else n_pass++;
    n_total++;
    if (pop_cnt - p0 !== 3 || fifo_q.size() !== 1) begin
      $display("FAIL under_pops: got pops=%0d left=%0d expected pops=3 left=1", pop_cnt - p0, fifo_q.size());
    end else n_pass++;
    n_total++;
    fifo_q.delete();
    tick();
  endtask

  task automatic test_abort();
    int p0;
    int dones;
    p0 = pop_cnt;
    dones = 0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'hC0 + i);
    start_burst(8'd7);                       // T+1
    tick();                                  // T+2
    tick();                                  // T+3
    if (bus.DATAIN !== 32'hC1) begin $display("FAIL abort_beat1: got %h expected c1", bus.DATAIN); end else n_pass++;
    n_total++;
    bus.WR_ABORT = 1'b1;
    #1;
    if (bus.FIFO_RDREQ !== 1'b0) begin $display("FAIL abort_rdreq: got %b expected 0", bus.FIFO_RDREQ); end else n_pass++;
    n_total++;
    tick();                                  // T+4
    bus.WR_ABORT = 1'b0;
    if (bus.WR_BUSY !== 1'b0 || bus.DM !== 4'hF || bus.DATAIN !== 32'h0) begin
      $display("FAIL abort_masked: got busy=%b dm=%h data=%h expected busy=0 dm=f data=0", bus.WR_BUSY, bus.DM, bus.DATAIN);
    end else n_pass++;
    n_total++;
    for (int i = 0; i < 8; i++) begin
      if (bus.WR_DONE) dones++;
      tick();
    end
    if (dones !== 0) begin $display("FAIL abort_no_done: got %0d expected 0", dones); end else n_pass++;
    n_total++;
    if (pop_cnt - p0 !== 2 || fifo_q.size() !== 6 || fifo_q[0] !== 32'hC2) begin
      $display("FAIL abort_fifo: got pops=%0d left=%0d expected pops=2 left=6", pop_cnt - p0, fifo_q.size());
    end else n_pass++;
    n_total++;
    fifo_q.delete();
    tick();
  endtask

  task automatic test_restart();
    // First burst runs on an empty FIFO so UNDERRUN is set.
    start_burst(8'd3);                       // T+1
    tick();                                  // T+2: re-pulse with a different length
    if (bus.UNDERRUN !== 1'b1) begin $display("FAIL restart_und_set: got %b expected 1", bus.UNDERRUN); end else n_pass++;
    n_total++;
    bus.WR_LEN   = 8'd0;
    bus.WR_START = 1'b1;
    tick();                                  // T+3
    bus.WR_START = 1'b0;
    tick();                                  // T+4
    if (bus.WR_BUSY !== 1'b1 || bus.WR_DONE !== 1'b0) begin
      $display("FAIL restart_ignored: got busy=%b done=%b expected busy=1 done=0", bus.WR_BUSY, bus.WR_DONE);
    end else n_pass++;
    n_total++;
    tick();                                  // T+5: first idle cycle
    if (bus.WR_DONE !== 1'b1 || bus.WR_BUSY !== 1'b0) begin
      $display("FAIL restart_done: got done=%b busy=%b expected done=1 busy=0", bus.WR_DONE, bus.WR_BUSY);
    end else n_pass++;
    n_total++;
    fifo_q.push_back(32'hD0);
    fifo_q.push_back(32'hD1);
    start_burst(8'd1);                       // T+6
    if (bus.WR_BUSY !== 1'b1 || bus.UNDERRUN !== 1'b0 || bus.DM !== 4'hF) begin
      $display("FAIL restart_accept: got busy=%b und=%b dm=%h expected busy=1 und=0 dm=f", bus.WR_BUSY, bus.UNDERRUN, bus.DM);
    end else n_pass++;
    n_total++;
    tick();                                  // T+7
    if (bus.DATAIN !== 32'hD0 || bus.DM !== 4'h0) begin
      $display("FAIL restart_beat0: got %h/%h expected d0/0", bus.DATAIN, bus.DM);
    end else n_pass++;
    n_total++;
    tick();                                  // T+8
    if (bus.DATAIN !== 32'hD1 || bus.WR_DONE !== 1'b1) begin
      $display("FAIL restart_beat1: got %h done=%b expected d1 done=1", bus.DATAIN, bus.WR_DONE);
    end else n_pass++;
    n_total++;
    tick();
  endtask

  task automatic test_len_bounds();
    int p0;
    int dones;
    int beat_err;
    int nbeats;
    logic [DSIZE-1:0] exp;
    // Single-beat burst.
    fifo_q.push_back(32'hE0);
    start_burst(8'd0);                       // T+1
    tick();                                  // T+2
    if (bus.DATAIN !== 32'hE0 || bus.DM !== 4'h0 || bus.WR_DONE !== 1'b1) begin
      $display("FAIL len0_beat: got %h/%h done=%b expected e0/0 done=1", bus.DATAIN, bus.DM, bus.WR_DONE);
    end else n_pass++;
    n_total++;
    tick();                                  // T+3
    if (bus.WR_DONE !== 1'b0 || bus.DM !== 4'hF || bus.WR_BUSY !== 1'b0) begin
      $display("FAIL len0_after: got done=%b dm=%h busy=%b expected done=0 dm=f busy=0", bus.WR_DONE, bus.DM, bus.WR_BUSY);
    end else n_pass++;
    n_total++;
    // Maximum-length burst.
    nbeats = int'(burst_beats(8'd255));
    for (int i = 0; i < 256; i++) begin
      fifo_q.push_back(32'h5500_0000 + i);
      exp_q.push_back(32'h5500_0000 + i);
    end
    p0 = pop_cnt;
    dones = 0;
    beat_err = 0;
    start_burst(8'd255);                     // T+1
    for (int k = 0; k < nbeats; k++) begin
      tick();                                // T+2+k
      exp = exp_q.pop_front();
      if (bus.DATAIN !== exp || bus.DM !== 4'h0) beat_err++;
      if (bus.WR_DONE) begin
        dones++;
        if (k != 255) beat_err++;
      end
    end
    if (beat_err !== 0) begin $display("FAIL len255_beats: got %0d bad beats expected 0", beat_err); end else n_pass++;
    n_total++;
    tick();
    if (bus.WR_DONE) dones++;
    if (dones !== 1) begin $display("FAIL len255_done: got %0d pulses expected 1", dones); end else n_pass++;
    n_total++;
    if (pop_cnt - p0 !== 256 || bus.DM !== 4'hF) begin
      $display("FAIL len255_pops: got pops=%0d dm=%h expected pops=256 dm=f", pop_cnt - p0, bus.DM);
    end else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_mid_burst();
    int p0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'hF0 + i);
    start_burst(8'd7);                       // T+1
    for (int i = 0; i < 5; i++) tick();      // T+6: beat 4
    if (bus.DATAIN !== 32'hF4) begin $display("FAIL rst_mid_beat4: got %h expected f4", bus.DATAIN); end else n_pass++;
    n_total++;
    RESET_N = 1'b0;
    #1;
    if (bus.DATAIN !== 32'h0 || bus.DM !== 4'hF || bus.WR_BUSY !== 1'b0 || bus.FIFO_RDREQ !== 1'b0 || STATE_DBG !== ST_IDLE) begin
      $display("FAIL rst_mid_async: got data=%h dm=%h busy=%b rdreq=%b expected 0/f/0/0", bus.DATAIN, bus.DM, bus.WR_BUSY, bus.FIFO_RDREQ);
    end else n_pass++;
    n_total++;
    tick(); tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    if (pop_cnt - p0 !== 5 || fifo_q.size() !== 3 || bus.WR_BUSY !== 1'b0) begin
      $display("FAIL rst_mid_fifo: got pops=%0d left=%0d busy=%b expected pops=5 left=3 busy=0", pop_cnt - p0, fifo_q.size(), bus.WR_BUSY);
    end else n_pass++;
    n_total++;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_basic_burst();
    test_underrun();
    test_abort();
    test_restart();
    test_len_bounds();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
